// File: rtl/fpnew_pkg.sv
// Shared configuration types and helpers for the shared-issue FPU scheduler.
package fpnew_pkg;

  typedef struct packed {
    int unsigned num_req;
    int unsigned max_outstanding;
  } sched_cfg_t;

  localparam sched_cfg_t DefaultSchedCfg = '{num_req: 32'd4, max_outstanding: 32'd4};

  // First set bit of mask at or after ptr, wrapping modulo n (n <= 32); returns ptr if none.
  function automatic int unsigned rr_next_idx(input int unsigned ptr,
                                              input logic [31:0] mask,
                                              input int unsigned n);
    int unsigned res;
    int unsigned idx;
    logic        found;
    res   = ptr;
    found = 1'b0;
    for (int unsigned off = 0; off < 32; off++) begin
      if (!found && off < n) begin
        idx = (ptr + off) % n;
        if (mask[idx[4:0]]) begin
          res   = idx;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fpnew_sched_credit_cnt.sv
// Per-requester in-flight credit counter: saturating up/down with flush to zero.
module fpnew_sched_credit_cnt #(
  parameter int MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic flush_i,
  output logic full_o,
  output logic zero_o
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_inc, do_dec;

  assign full_o = (cnt_q == CntWidth'(MaxOutstanding));
  assign zero_o = (cnt_q == '0);

  always_comb begin
    do_inc = inc_i & ~full_o;
    do_dec = dec_i & ~zero_o;
    cnt_d  = cnt_q;
    // Flush wins; a simultaneous issue and retire leaves the count untouched.
    if (flush_i)               cnt_d = '0;
    else if (do_inc && !do_dec) cnt_d = cnt_q + CntWidth'(1);
    else if (do_dec && !do_inc) cnt_d = cnt_q - CntWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fpnew_shared_issue_sched.sv
// Shares one FPU between NumReq requesters: round-robin issue with tags, credit limits,
// and tag-based routing of (possibly out-of-order) results back to their owners.
module fpnew_shared_issue_sched
  import fpnew_pkg::*;
#(
  parameter int NumReq         = 4,
  parameter int PayloadWidth   = 128,
  parameter int ResultWidth    = 37,
  parameter int MaxOutstanding = 4,
  localparam int IdxWidth      = $clog2(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]  req_data_i,
  output logic                                 fpu_valid_o,
  input  logic                                 fpu_ready_i,
  output logic [PayloadWidth-1:0]              fpu_data_o,
  output logic [IdxWidth-1:0]                  fpu_tag_o,
  input  logic                                 fpu_out_valid_i,
  output logic                                 fpu_out_ready_o,
  input  logic [ResultWidth-1:0]               fpu_result_i,
  input  logic [IdxWidth-1:0]                  fpu_tag_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [ResultWidth-1:0]               rsp_result_o,
  input  logic                                 flush_i,
  output logic                                 busy_o
);

  logic                    issue_valid_q, issue_valid_d;
  logic [PayloadWidth-1:0] data_q, data_d;
  logic [IdxWidth-1:0]     tag_q, tag_d;
  logic [IdxWidth-1:0]     ptr_q, ptr_d;

  logic [NumReq-1:0]   full, zero, eligible, grant_oh, inc, dec, tag_hit, live;
  logic [IdxWidth-1:0] grant_idx;
  logic                loadable, load, tag_live;

  always_comb begin
    eligible    = req_valid_i & ~full;
    grant_idx   = IdxWidth'(rr_next_idx(32'(ptr_q), 32'(eligible), NumReq));
    grant_oh    = NumReq'(1) << grant_idx;
    loadable    = ~issue_valid_q | fpu_ready_i;
    load        = loadable & (|eligible) & ~flush_i & ~rst_i;
    req_ready_o = load ? grant_oh : '0;
    inc         = req_ready_o & req_valid_i;
  end

  always_comb begin
    issue_valid_d = issue_valid_q;
    data_d        = data_q;
    tag_d         = tag_q;
    ptr_d         = ptr_q;
    if (flush_i) begin
      issue_valid_d = 1'b0;
    end else if (load) begin
      issue_valid_d = 1'b1;
      data_d        = req_data_i[grant_idx];
      tag_d         = grant_idx;
      ptr_d         = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + IdxWidth'(1);
    end else if (fpu_ready_i) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_valid_q <= 1'b0;
      data_q        <= '0;
      tag_q         <= '0;
      ptr_q         <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      data_q        <= data_d;
      tag_q         <= tag_d;
      ptr_q         <= ptr_d;
    end
  end

  assign fpu_valid_o = issue_valid_q;
  assign fpu_data_o  = data_q;
  assign fpu_tag_o   = tag_q;

  // Results with an unknown tag or no outstanding credit are drained silently.
  always_comb begin
    for (int k = 0; k < NumReq; k++) tag_hit[k] = (fpu_tag_i == IdxWidth'(k));
    live            = tag_hit & ~zero;
    tag_live        = |live;
    rsp_valid_o     = (fpu_out_valid_i & ~flush_i) ? live : '0;
    fpu_out_ready_o = (flush_i | ~tag_live) ? 1'b1 : |(tag_hit & rsp_ready_i);
    dec             = rsp_valid_o & rsp_ready_i;
  end

  assign rsp_result_o = fpu_result_i;
  assign busy_o       = issue_valid_q | ~(&zero);

  for (genvar i = 0; i < NumReq; i++) begin : g_cnt
    fpnew_sched_credit_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (inc[i]),
      .dec_i  (dec[i]),
      .flush_i(flush_i),
      .full_o (full[i]),
      .zero_o (zero[i])
    );
  end

  a_result_tag_live: assert property (@(posedge clk_i) disable iff (rst_i)
      (fpu_out_valid_i && !flush_i) |-> tag_live)
    else $error("result with invalid tag or no outstanding credit");

endmodule
